cordic_arbiter: RTL and testbench
=================================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameters (one per line: name, default, meaning):
  NUM_REQ, 4, requester count (2..8)
  ITER_BITS, 4, CORDIC iteration-count width (passed through to package users)
  Q1_14_BITS, 16, sine/cosine/x/y width
  Q4_27_BITS, 32, angle width
  TIMEOUT, 64, max cycles from core_start to core_out_valid
REQ-002 Ports (one per line: name direction width meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-low reset (0 = reset asserted)
  req_valid  in  NUM_REQ  per-requester angle valid
  req_angle  in  NUM_REQ*Q4_27_BITS  packed Q4.27 angles, requester i at slice i
  req_ready  out  NUM_REQ  one-hot accept for the requester's angle
  resp_valid  out  NUM_REQ  one-hot result valid
  resp_ready  in  NUM_REQ  per-requester result accept
  resp_sine  out  Q1_14_BITS  shared result bus, Q1.14
  resp_cosine  out  Q1_14_BITS  shared result bus, Q1.14
  core_in_ready  in  1  core can accept a new angle
  core_start  out  1  one-cycle start pulse to the core
  core_angle  out  Q4_27_BITS  angle to the core
  core_x_start  out  Q1_14_BITS  constant COS_CONST
  core_y_start  out  Q1_14_BITS  constant 0
  core_out_valid  in  1  one-cycle result pulse from the core
  core_sine, core_cosine  in  Q1_14_BITS each  core results
  err_timeout  out  1  sticky timeout flag
  err_spurious  out  1  sticky flag for core_out_valid outside WAIT

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT, RESP; one core transaction outstanding at a time.
REQ-004 IDLE: if any req_valid is set, select winner i round-robin starting at pointer ptr; assert req_ready[i] for exactly that cycle; latch req_angle slice i into core_angle and latch owner i; go to ISSUE.
REQ-005 ptr resets to 0; after granting i, ptr becomes (i+1) mod NUM_REQ.
REQ-006 ISSUE: when core_in_ready = 1, pulse core_start for one cycle, clear the timeout counter and go to WAIT; otherwise hold.
REQ-007 WAIT: on core_out_valid, register core_sine/core_cosine into resp_sine/resp_cosine and go to RESP. Start-to-result latency is set by the core.
REQ-008 WAIT: the counter increments each cycle; when it reaches TIMEOUT-1 without core_out_valid, set err_timeout, leave resp_valid low, drop the transaction and go to IDLE.
REQ-009 RESP: resp_valid[owner] is held high with stable data until resp_ready[owner] = 1; then go to IDLE. No new grant is issued while in RESP.
REQ-010 The next grant is earliest in the cycle after the RESP handshake, so the minimum per-transaction overhead outside the core is 3 cycles.
REQ-011 core_out_valid in IDLE, ISSUE or RESP is ignored and sets err_spurious.
REQ-012 core_x_start = COS_CONST (16'sh26dd) and core_y_start = 0 at all times, including during reset.
REQ-013 Simultaneous req_valid bits are resolved only by ptr. Requesters not granted keep req_valid and their angle stable; the arbiter does not check this.
REQ-014 All widths are exact with no arithmetic beyond the counter, which is ceil(log2(TIMEOUT)) bits wide and saturates.

Reset
REQ-015 While rst = 0: state = IDLE, ptr = 0, owner = 0, counter = 0, and req_ready, resp_valid, core_start, err_timeout, err_spurious, core_angle, resp_sine and resp_cosine are all 0.
REQ-016 Reset asserted mid-transaction discards it. After release, any core_out_valid from the old transaction sets err_spurious.
REQ-017 Error flags clear only on reset.

Structure
REQ-018 A shared package cordic_pkg holds Q1_14_BITS, Q4_27_BITS, ITER_BITS, COS_CONST, the angle constants (PIo4 = 32'sh06487ed5, PIo2 = 32'sh0c90fdaa, PI = 32'sh1921fb54) and the FSM state encoding.
REQ-019 Round-robin selection lives in a sub-module rr_arbiter (inputs: request vector, ptr; output: one-hot grant plus index). The FSM and datapath stay in cordic_arbiter.

Verification
REQ-020 Single request: req 0 sends PIo4 -> one core_start, then resp_valid[0] with sine ≈ cosine ≈ 16'sh2d41 (±2 LSB).
REQ-021 All four requesters valid at once after reset -> grants in order 0,1,2,3, each waits for the previous RESP; req 2 sends PIo2 -> sine ≈ 16'sh4000, cosine ≈ 0.
REQ-022 Backpressure: resp_ready[1] held low for 10 cycles -> resp_valid[1] and data stay stable, no core_start, then release -> IDLE.
REQ-023 Core stalled (core_out_valid never arrives) -> err_timeout rises exactly TIMEOUT cycles after core_start, FSM returns to IDLE and the next request is served.
REQ-024 Reset asserted in WAIT, then a late core_out_valid -> all outputs 0 during reset, err_spurious = 1 after the pulse, no resp_valid.
REQ-025 core_in_ready low for 5 cycles in ISSUE -> core_start delayed until it rises and stays a single-cycle pulse.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, angle constants and arbiter state encoding
package cordic_pkg;
    localparam int Q1_14_BITS = 16;
    localparam int Q4_27_BITS = 32;
    localparam int ITER_BITS  = 4;
    localparam logic signed [Q1_14_BITS-1:0] COS_CONST = 16'sh26dd;
    localparam logic signed [Q4_27_BITS-1:0] PIo4 = 32'sh06487ed5;
    localparam logic signed [Q4_27_BITS-1:0] PIo2 = 32'sh0c90fdaa;
    localparam logic signed [Q4_27_BITS-1:0] PI   = 32'sh1921fb54;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx
);
    logic [PW-1:0] j;

    // Scan from the farthest offset down so the nearest request to ptr wins last
    always_comb begin
        grant = '0;
        idx = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC core among NUM_REQ requesters, one transaction at a time
module cordic_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ITER_BITS  = 4,
    parameter int Q1_14_BITS = 16,
    parameter int Q4_27_BITS = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*Q4_27_BITS-1:0] req_angle,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [Q1_14_BITS-1:0]         resp_sine,
    output logic [Q1_14_BITS-1:0]         resp_cosine,
    input  logic                          core_in_ready,
    output logic                          core_start,
    output logic [Q4_27_BITS-1:0]         core_angle,
    output logic [Q1_14_BITS-1:0]         core_x_start,
    output logic [Q1_14_BITS-1:0]         core_y_start,
    input  logic                          core_out_valid,
    input  logic [Q1_14_BITS-1:0]         core_sine,
    input  logic [Q1_14_BITS-1:0]         core_cosine,
    output logic                          err_timeout,
    output logic                          err_spurious
);
    import cordic_pkg::*;

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || ITER_BITS < 1) begin : g_bad_param
        $error("cordic_arbiter: unsupported parameter values");
    end

    state_t             state;
    logic [PW-1:0]      ptr, owner, win_idx;
    logic [NUM_REQ-1:0] win_grant;
    logic [CW-1:0]      cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req(req_valid),
        .ptr(ptr),
        .grant(win_grant),
        .idx(win_idx)
    );

    assign core_x_start = Q1_14_BITS'(COS_CONST);
    assign core_y_start = '0;
    // Accept is combinational so the grant lands in the IDLE cycle itself; gated so reset forces it low
    assign req_ready = (state == IDLE && rst) ? win_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= '0;
            resp_valid   <= '0;
            core_start   <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            core_angle   <= '0;
            resp_sine    <= '0;
            resp_cosine  <= '0;
        end else begin
            core_start <= 1'b0;
            if (core_out_valid && state != WAIT) err_spurious <= 1'b1;
            case (state)
                IDLE: if (|req_valid) begin
                    core_angle <= req_angle[win_idx*Q4_27_BITS +: Q4_27_BITS];
                    owner      <= win_idx;
                    ptr        <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: if (core_in_ready) begin
                    core_start <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: if (core_out_valid) begin
                    resp_sine   <= core_sine;
                    resp_cosine <= core_cosine;
                    resp_valid  <= NUM_REQ'(1) << owner;
                    state       <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= IDLE;
                end else begin
                    cnt <= (&cnt) ? cnt : cnt + 1'b1;
                end
                RESP: if (resp_ready[owner]) begin
                    resp_valid <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed checks of grant order, handshakes, timeout and reset handling
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0, rst = 1'b0;
    logic [N-1:0]    req_valid = '0, resp_ready = '0;
    logic [N-1:0]    req_ready, resp_valid;
    logic [N*32-1:0] req_angle = '0;
    logic [15:0]     resp_sine, resp_cosine, core_x_start, core_y_start;
    logic [15:0]     core_sine = '0, core_cosine = '0;
    logic            core_in_ready = 1'b1, core_out_valid = 1'b0;
    logic            core_start, err_timeout, err_spurious;
    logic [31:0]     core_angle;
    int              passed = 0, total = 0, starts = 0, s0, n;
    logic [15:0]     exp_s [4] = '{16'h2d41, 16'h0000, 16'h4000, 16'h0000};
    logic [15:0]     exp_c [4] = '{16'h2d41, 16'hc000, 16'h0000, 16'h4000};

    cordic_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sine(resp_sine), .resp_cosine(resp_cosine),
        .core_in_ready(core_in_ready), .core_start(core_start), .core_angle(core_angle),
        .core_x_start(core_x_start), .core_y_start(core_y_start),
        .core_out_valid(core_out_valid), .core_sine(core_sine), .core_cosine(core_cosine),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (core_start) starts++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!core_start && k < 20) begin
            tick();
            k++;
        end
        check("start_seen", core_start, 1);
    endtask

    task automatic reply(input logic [15:0] s, input logic [15:0] c);
        core_sine = s;
        core_cosine = c;
        core_out_valid = 1'b1;
        tick();
        core_out_valid = 1'b0;
    endtask

    initial begin
        req_valid = '1;
        repeat (2) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_angle", core_angle, 0);
        check("rst_errs", {err_timeout, err_spurious}, 0);
        check("rst_resp_data", {resp_sine, resp_cosine}, 0);
        check("x_start", core_x_start, 16'h26dd);
        check("y_start", core_y_start, 0);

        rst = 1'b1;
        req_angle[31:0] = PIo4;
        req_valid = 4'b0001;
        #1 check("t1_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("t1_angle", core_angle, PIo4);
        wait_start();
        tick();
        check("t1_pulse_end", core_start, 0);
        reply(16'h2d41, 16'h2d41);
        check("t1_resp_valid", resp_valid, 4'b0001);
        check("t1_sine", resp_sine, 16'h2d41);
        check("t1_cosine", resp_cosine, 16'h2d41);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        check("t1_done", resp_valid, 0);
        check("t1_starts", starts, 1);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_angle = {32'h0, PIo2, PI, PIo4};
        req_valid = '1;
        for (int i = 0; i < 4; i++) begin
            #1 check("t2_grant", req_ready, 4'b0001 << i);
            tick();
            req_valid[i] = 1'b0;
            check("t2_angle", core_angle, req_angle[i*32 +: 32]);
            wait_start();
            reply(exp_s[i], exp_c[i]);
            check("t2_resp_valid", resp_valid, 4'b0001 << i);
            check("t2_sine", resp_sine, exp_s[i]);
            check("t2_cosine", resp_cosine, exp_c[i]);
            check("t2_no_grant_in_resp", req_ready, 0);
            resp_ready = 4'b0001 << i;
            tick();
            resp_ready = '0;
        end

        req_valid = 4'b0010;
        #1 check("t3_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0001;
        wait_start();
        reply(16'h0000, 16'hc000);
        s0 = starts;
        for (int k = 0; k < 10; k++) begin
            check("t3_hold_valid", resp_valid, 4'b0010);
            check("t3_hold_data", {resp_sine, resp_cosine}, 32'h0000c000);
            check("t3_hold_no_grant", req_ready, 0);
            tick();
        end
        check("t3_no_start", starts, s0);
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        check("t3_released", resp_valid, 0);
        #1 check("t3_next_grant", req_ready, 4'b0001);

        tick();
        req_valid = '0;
        wait_start();
        n = 0;
        while (!err_timeout && n < 100) begin
            tick();
            n++;
        end
        check("t4_timeout_latency", n, TO);
        check("t4_no_resp", resp_valid, 0);
        core_in_ready = 1'b0;
        req_valid = 4'b1000;
        #1 check("t4_next_grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        s0 = starts;
        repeat (5) begin
            check("t5_start_held", core_start, 0);
            tick();
        end
        core_in_ready = 1'b1;
        tick();
        check("t5_start", core_start, 1);
        tick();
        check("t5_start_end", core_start, 0);
        check("t5_one_start", starts, s0 + 1);
        reply(16'h0000, 16'h4000);
        check("t5_resp_valid", resp_valid, 4'b1000);
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;
        check("t5_timeout_sticky", err_timeout, 1);
        check("t5_no_spurious", err_spurious, 0);

        req_valid = 4'b0010;
        #1 check("t6_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_start();
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_outputs", {resp_valid, core_start, err_timeout, err_spurious}, 0);
        check("t6_rst_data", {core_angle, resp_sine, resp_cosine}, 0);
        check("t6_rst_x_start", core_x_start, 16'h26dd);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("t6_pre_spurious", err_spurious, 0);
        reply(16'h1234, 16'h5678);
        check("t6_spurious", err_spurious, 1);
        check("t6_no_resp", resp_valid, 0);
        tick();
        check("t6_no_resp_later", resp_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
